// File: rtl/alu_writeback_buffer.sv
`default_nettype none
// ============================================================================
// Module  : alu_writeback_buffer
// Purpose : Sits directly behind the ALU. Captures each ALU result, turns a
//           branch-on-zero into a one-cycle taken pulse with its target, and
//           queues register writes in a small FIFO that drains into the
//           register-file write port under valid/ready backpressure.
// Ports   : clk, rst              - clock, synchronous active-high reset
//           in_valid/in_ready     - ALU result handshake
//           in_result, in_zero    - ALU data_out and zero flag
//           in_rd, in_reg_write   - destination register and write enable
//           in_branch, in_target  - branch-on-zero flag and target address
//           flush                 - discard every queued entry
//           wb_valid/wb_ready     - register-file write handshake
//           wb_rd, wb_data        - head entry (zero when empty)
//           branch_taken/_target  - one-cycle taken pulse and its target
//           count                 - current FIFO occupancy
// Revision: 1.0 - initial release
// ============================================================================
module alu_writeback_buffer #(
   parameter int RISC_V_DATA_WIDTH = 32,
   parameter int REG_ADDR_WIDTH    = 5,
   parameter int DEPTH             = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [RISC_V_DATA_WIDTH-1:0] in_result,
   input  logic                         in_zero,
   input  logic [REG_ADDR_WIDTH-1:0]    in_rd,
   input  logic                         in_reg_write,
   input  logic                         in_branch,
   input  logic [RISC_V_DATA_WIDTH-1:0] in_target,
   input  logic                         flush,
   output logic                         wb_valid,
   input  logic                         wb_ready,
   output logic [REG_ADDR_WIDTH-1:0]    wb_rd,
   output logic [RISC_V_DATA_WIDTH-1:0] wb_data,
   output logic                         branch_taken,
   output logic [RISC_V_DATA_WIDTH-1:0] branch_target,
   output logic [$clog2(DEPTH):0]       count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int EW = REG_ADDR_WIDTH + RISC_V_DATA_WIDTH;
   localparam logic [CW-1:0] C_DEPTH   = CW'(DEPTH);
   localparam logic [CW-1:0] C_CNT_ONE = CW'(1);
   localparam logic [PW-1:0] C_PTR_ONE = PW'(1);

   // Storage holds {rd, data}; not reset because the outputs are gated
   // by occupancy and never expose a stale slot.
   logic [EW-1:0]                mem_q [DEPTH];
   logic [PW-1:0]                wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]                rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]                count_q, count_d;
   logic                         branch_taken_q, branch_taken_d;
   logic [RISC_V_DATA_WIDTH-1:0] branch_target_q, branch_target_d;
   logic                         mem_we_d;

   logic                         w_ready;
   logic                         w_valid;
   logic                         w_accept;
   logic                         w_push;
   logic                         w_pop;
   logic [EW-1:0]                w_head;

   // Handshake flags derive only from registered occupancy, so in_ready
   // never depends combinationally on wb_ready or in_valid.
   assign w_ready = (count_q < C_DEPTH);
   assign w_valid = (count_q != '0);
   assign w_head  = mem_q[rd_ptr_q];

   always_comb begin
      w_accept        = in_valid & w_ready;
      // x0 writes and non-writing instructions are consumed but not queued.
      w_push          = w_accept & in_reg_write & (in_rd != '0);
      w_pop           = w_valid & wb_ready;
      wr_ptr_d        = wr_ptr_q;
      rd_ptr_d        = rd_ptr_q;
      count_d         = count_q;
      branch_taken_d  = 1'b0;
      branch_target_d = branch_target_q;
      mem_we_d        = 1'b0;

      if (flush) begin
         // Any push, pop or branch in the flush cycle is discarded.
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         mem_we_d = w_push;
         if (w_push) begin
            wr_ptr_d = wr_ptr_q + C_PTR_ONE;
         end
         if (w_pop) begin
            rd_ptr_d = rd_ptr_q + C_PTR_ONE;
         end
         if (w_push && !w_pop) begin
            count_d = count_q + C_CNT_ONE;
         end else if (w_pop && !w_push) begin
            count_d = count_q - C_CNT_ONE;
         end
         // Branch resolves from the zero flag alone, never from the result.
         if (w_accept && in_branch && in_zero) begin
            branch_taken_d  = 1'b1;
            branch_target_d = in_target;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q        <= '0;
         rd_ptr_q        <= '0;
         count_q         <= '0;
         branch_taken_q  <= 1'b0;
         branch_target_q <= '0;
      end else begin
         wr_ptr_q        <= wr_ptr_d;
         rd_ptr_q        <= rd_ptr_d;
         count_q         <= count_d;
         branch_taken_q  <= branch_taken_d;
         branch_target_q <= branch_target_d;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we_d && !rst) begin
         mem_q[wr_ptr_q] <= {in_rd, in_result};
      end
   end

   assign in_ready      = w_ready;
   assign wb_valid      = w_valid;
   assign wb_rd         = w_valid ? w_head[EW-1 -: REG_ADDR_WIDTH] : '0;
   assign wb_data       = w_valid ? w_head[RISC_V_DATA_WIDTH-1:0] : '0;
   assign branch_taken  = branch_taken_q;
   assign branch_target = branch_target_q;
   assign count         = count_q;

endmodule
`default_nettype wire
